sl_pattern_sequencer: RTL and testbench

//  Frame-level controller for the structured-light DDS pattern path, in the clk_25 pixel domain.

---
 rtl/sl_pkg.sv | 18 +
 rtl/sl_pattern_sequencer_if.sv | 26 ++
 rtl/sl_pinc_div.sv | 58 +++++
 rtl/sl_pattern_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_sl_pattern_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sl_pkg.sv
// rtl/sl_pkg.sv - shared constants and state encoding for the structured-light pattern sequencer
package sl_pkg;

  localparam int K_MAX   = 60;
  localparam int N_STEPS = 8;

  // 2^32 / 8: phase increment numerator before dividing by K
  localparam logic [31:0] PINC_NUM = 32'h2000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RUN    = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/sl_pattern_sequencer_if.sv
// rtl/sl_pattern_sequencer_if.sv - frame sync, camera handshake and DDS control bundle
interface sl_pattern_sequencer_if;

  logic        sync_vs;
  logic        sync_in_1;
  logic        sync_in_2;
  logic [31:0] phase_inc;
  logic [31:0] poff;
  logic [7:0]  co_k;
  logic [7:0]  co_n;
  logic        cam_trig;
  logic        frame_mark;
  logic        busy;
  logic        done;

  modport master (
    output sync_vs, sync_in_1, sync_in_2,
    input  phase_inc, poff, co_k, co_n, cam_trig, frame_mark, busy, done
  );

  modport slave (
    input  sync_vs, sync_in_1, sync_in_2,
    output phase_inc, poff, co_k, co_n, cam_trig, frame_mark, busy, done
  );

endinterface

// File: rtl/sl_pinc_div.sv
// rtl/sl_pinc_div.sv - 32-cycle restoring unsigned divider with start/busy/valid handshake
module sl_pinc_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num,
  input  logic [31:0] den,
  output logic        busy,
  output logic        valid,
  output logic [31:0] quo
);

  logic [31:0] rem;
  logic [31:0] dvs;
  logic [5:0]  cnt;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  // quo doubles as the dividend shift register; bit 32 of diff is the borrow
  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      dvs   <= '0;
      quo   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        quo  <= num;
        dvs  <= den;
        rem  <= '0;
        cnt  <= 6'd32;
        busy <= 1'b1;
      end else if (busy) begin
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= rem_sh[31:0];
          quo <= {quo[30:0], 1'b0};
        end
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sl_pattern_sequencer.sv
// rtl/sl_pattern_sequencer.sv - steps K x n phase-shift patterns per video frame and drives camera sync
module sl_pattern_sequencer #(
  parameter int K_MAX       = sl_pkg::K_MAX,
  parameter int N_STEPS     = sl_pkg::N_STEPS,
  parameter int SETTLE_FRMS = 2,
  parameter int TRIG_CYCLES = 16,
  parameter int MARK_STEP   = 1,
  parameter int LOOP        = 0
) (
  input  logic                 clk_25,
  input  logic                 reset,
  sl_pattern_sequencer_if.slave bus
);
  import sl_pkg::*;

  localparam int NB   = $clog2(N_STEPS);
  localparam int NPAT = K_MAX * N_STEPS;
  localparam int IW   = $clog2(NPAT);

  logic [1:0]    vs_sr, t_sr, r_sr;
  logic          vs_d;
  logic          fb, trig_en, ready;
  state_t        state;
  logic [IW-1:0] idx;
  logic          fin, pend, calc, shadow_valid;
  logic [31:0]   shadow_pinc;
  logic [7:0]    settle_cnt;
  logic [15:0]   trig_cnt;
  logic [31:0]   phase_inc_r, poff_r;
  logic [7:0]    co_k_r, co_n_r;
  logic          cam_trig_r, frame_mark_r, busy_r, done_r;
  logic [7:0]    k_cur, n_cur;
  logic [31:0]   poff_cur, div_num, div_den, div_q;
  logic          div_busy, div_valid;
  logic          boundary, take;

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      vs_sr <= '0;
      t_sr  <= '0;
      r_sr  <= '0;
      vs_d  <= 1'b0;
    end else begin
      vs_sr <= {vs_sr[0], bus.sync_vs};
      t_sr  <= {t_sr[0], bus.sync_in_1};
      r_sr  <= {r_sr[0], bus.sync_in_2};
      vs_d  <= vs_sr[1];
    end
  end

  assign fb      = vs_d & ~vs_sr[1];
  assign trig_en = t_sr[1];
  assign ready   = r_sr[1];

  assign n_cur    = 8'(idx[NB-1:0]);
  assign k_cur    = 8'(idx[IW-1:NB]) + 8'd1;
  assign poff_cur = {idx[NB-1:0], {(32-NB){1'b0}}};
  assign div_num  = PINC_NUM + 32'(k_cur >> 1);
  assign div_den  = 32'(k_cur);

  // A late shadow (pend) defers the output load and index advance until the divider finishes
  assign boundary = fb && trig_en && ready && !fin && (state == RUN || state == HOLD);
  assign take     = trig_en && shadow_valid && !div_busy && (boundary || pend);

  sl_pinc_div u_div (
    .clk   (clk_25),
    .rst   (reset),
    .start (calc),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .valid (div_valid),
    .quo   (div_q)
  );

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      fin          <= 1'b0;
      pend         <= 1'b0;
      calc         <= 1'b0;
      shadow_valid <= 1'b1;
      shadow_pinc  <= PINC_NUM;
      settle_cnt   <= '0;
      trig_cnt     <= '0;
      phase_inc_r  <= PINC_NUM;
      poff_r       <= '0;
      co_k_r       <= 8'd1;
      co_n_r       <= '0;
      cam_trig_r   <= 1'b0;
      frame_mark_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      calc         <= 1'b0;
      frame_mark_r <= (co_n_r == 8'(MARK_STEP)) && busy_r;

      if (cam_trig_r) begin
        if (trig_cnt == '0) cam_trig_r <= 1'b0;
        else                trig_cnt   <= trig_cnt - 16'd1;
      end
      if (div_valid && !calc) begin
        shadow_pinc  <= div_q;
        shadow_valid <= 1'b1;
      end
      if (boundary) begin
        cam_trig_r <= 1'b1;
        trig_cnt   <= 16'(TRIG_CYCLES - 1);
        pend       <= 1'b1;
      end
      if (take) begin
        phase_inc_r  <= shadow_pinc;
        poff_r       <= poff_cur;
        co_k_r       <= k_cur;
        co_n_r       <= n_cur;
        pend         <= 1'b0;
        calc         <= 1'b1;
        shadow_valid <= 1'b0;
        if (idx == IW'(NPAT - 1)) begin
          idx <= '0;
          if (LOOP == 0) fin <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end

      if (!trig_en && state != IDLE) begin
        state        <= IDLE;
        idx          <= '0;
        fin          <= 1'b0;
        pend         <= 1'b0;
        calc         <= 1'b1;
        shadow_valid <= 1'b0;
        cam_trig_r   <= 1'b0;
        busy_r       <= 1'b0;
        done_r       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fb) begin
              phase_inc_r <= PINC_NUM;
              poff_r      <= '0;
              co_k_r      <= 8'd1;
              co_n_r      <= '0;
            end
            if (trig_en) begin
              state      <= SETTLE;
              settle_cnt <= '0;
              busy_r     <= 1'b1;
            end
          end
          SETTLE: begin
            if (!ready) begin
              settle_cnt <= '0;
            end else if (fb) begin
              settle_cnt <= settle_cnt + 8'd1;
              if (settle_cnt == 8'(SETTLE_FRMS - 1)) state <= RUN;
            end
          end
          RUN, HOLD: begin
            // fin: the last pattern has had its full frame, so this boundary ends the sweep
            if (fb) begin
              if (!ready) begin
                state <= HOLD;
              end else if (fin) begin
                state  <= DONE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.phase_inc  = phase_inc_r;
  assign bus.poff       = poff_r;
  assign bus.co_k       = co_k_r;
  assign bus.co_n       = co_n_r;
  assign bus.cam_trig   = cam_trig_r;
  assign bus.frame_mark = frame_mark_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_sl_pattern_sequencer.sv
// tb/tb_sl_pattern_sequencer.sv - directed bench for sl_pattern_sequencer, LOOP=0 and LOOP=1 side by side
module tb_sl_pattern_sequencer;

  logic clk_25 = 1'b0;
  logic reset;
  logic vs, in1, in2;
  int   total = 0;
  int   bad   = 0;
  int   tc0, tc1;

  always #5 clk_25 = ~clk_25;

  sl_pattern_sequencer_if bus0 ();
  sl_pattern_sequencer_if bus1 ();

  assign bus0.sync_vs   = vs;
  assign bus0.sync_in_1 = in1;
  assign bus0.sync_in_2 = in2;
  assign bus1.sync_vs   = vs;
  assign bus1.sync_in_1 = in1;
  assign bus1.sync_in_2 = in2;

  sl_pattern_sequencer #(.LOOP(0)) u0 (.clk_25(clk_25), .reset(reset), .bus(bus0.slave));
  sl_pattern_sequencer #(.LOOP(1)) u1 (.clk_25(clk_25), .reset(reset), .bus(bus1.slave));

  typedef struct {
    int          idx;
    int          k;
    int          n;
    logic [63:0] pinc;
    logic [63:0] poff;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string t, input logic [31:0] pi, input logic [31:0] po,
                         input logic [7:0] k, input logic [7:0] n, input logic ct,
                         input logic fm, input logic b, input logic d);
    chk({t, "_pinc"}, 64'(pi), 64'd536870912);
    chk({t, "_poff"}, 64'(po), 64'd0);
    chk({t, "_k"},    64'(k),  64'd1);
    chk({t, "_n"},    64'(n),  64'd0);
    chk({t, "_trig"}, 64'(ct), 64'd0);
    chk({t, "_mark"}, 64'(fm), 64'd0);
    chk({t, "_busy"}, 64'(b),  64'd0);
    chk({t, "_done"}, 64'(d),  64'd0);
  endtask

  function automatic logic [63:0] model_pinc(input int k);
    return ((64'd1 << 32) + 64'(4 * k)) / 64'(8 * k);
  endfunction

  // One 48-cycle video frame; vsync high for the first 4 cycles, cam_trig cycles counted
  task automatic frame();
    tc0 = 0;
    tc1 = 0;
    for (int c = 0; c < 48; c++) begin
      vs = (c < 4);
      @(negedge clk_25);
      if (bus0.cam_trig) tc0++;
      if (bus1.cam_trig) tc1++;
    end
  endtask

  initial begin
    reset = 1'b1;
    vs    = 1'b0;
    in1   = 1'b0;
    in2   = 1'b0;
    vecs[0] = '{8,   2,  0, 64'd268435456, 64'd0};
    vecs[1] = '{11,  2,  3, 64'd268435456, 64'd1610612736};
    vecs[2] = '{15,  2,  7, 64'd268435456, 64'd3758096384};
    vecs[3] = '{16,  3,  0, 64'd178956971, 64'd0};
    vecs[4] = '{48,  7,  0, 64'd76695845,  64'd0};
    vecs[5] = '{100, 13, 4, 64'd41297762,  64'd2147483648};
    vecs[6] = '{479, 60, 7, 64'd8947849,   64'd3758096384};

    repeat (3) @(negedge clk_25);
    chk_rst("init0", bus0.phase_inc, bus0.poff, bus0.co_k, bus0.co_n,
            bus0.cam_trig, bus0.frame_mark, bus0.busy, bus0.done);
    reset = 1'b0;
    in1   = 1'b1;
    in2   = 1'b1;

    frame();
    frame();
    chk("settle_busy", 64'(bus0.busy), 64'd1);
    chk("settle_no_trig", 64'(tc0), 64'd0);
    frame();
    chk("first_trig", 64'(tc0), 64'd16);
    chk("first_pinc", 64'(bus0.phase_inc), 64'd536870912);
    chk("first_poff", 64'(bus0.poff), 64'd0);
    chk("first_k", 64'(bus0.co_k), 64'd1);
    chk("first_mark", 64'(bus0.frame_mark), 64'd0);
    frame();
    chk("second_n", 64'(bus0.co_n), 64'd1);
    chk("second_poff", 64'(bus0.poff), 64'd536870912);
    chk("second_mark", 64'(bus0.frame_mark), 64'd1);

    in2 = 1'b0;
    for (int h = 0; h < 3; h++) begin
      frame();
      chk($sformatf("hold%0d_n", h), 64'(bus0.co_n), 64'd1);
      chk($sformatf("hold%0d_trig", h), 64'(tc0), 64'd0);
      chk($sformatf("hold%0d_busy", h), 64'(bus0.busy), 64'd1);
    end
    in2 = 1'b1;
    frame();
    chk("resume_n", 64'(bus0.co_n), 64'd2);
    chk("resume_trig", 64'(tc0), 64'd16);

    for (int d = 3; d <= 479; d++) begin
      frame();
      chk($sformatf("sw%0d_k0", d), 64'(bus0.co_k), 64'(d / 8 + 1));
      chk($sformatf("sw%0d_n0", d), 64'(bus0.co_n), 64'(d % 8));
      chk($sformatf("sw%0d_pinc0", d), 64'(bus0.phase_inc), model_pinc(d / 8 + 1));
      chk($sformatf("sw%0d_poff0", d), 64'(bus0.poff), 64'(d % 8) << 29);
      chk($sformatf("sw%0d_trig0", d), 64'(tc0), 64'd16);
      chk($sformatf("sw%0d_mark0", d), 64'(bus0.frame_mark), 64'((d % 8) == 1));
      chk($sformatf("sw%0d_n1", d), 64'(bus1.co_n), 64'(d % 8));
      chk($sformatf("sw%0d_trig1", d), 64'(tc1), 64'd16);
      if (d >= 8 && d <= 15)
        chk($sformatf("k2_pinc%0d", d), 64'(bus0.phase_inc), 64'd268435456);
      for (int v = 0; v < 7; v++) begin
        if (vecs[v].idx == d) begin
          chk($sformatf("vec%0d_k", d), 64'(bus0.co_k), 64'(vecs[v].k));
          chk($sformatf("vec%0d_n", d), 64'(bus0.co_n), 64'(vecs[v].n));
          chk($sformatf("vec%0d_pinc", d), 64'(bus0.phase_inc), vecs[v].pinc);
          chk($sformatf("vec%0d_poff", d), 64'(bus0.poff), vecs[v].poff);
        end
      end
    end
    chk("last_busy0", 64'(bus0.busy), 64'd1);

    frame();
    chk("end_done0", 64'(bus0.done), 64'd1);
    chk("end_busy0", 64'(bus0.busy), 64'd0);
    chk("end_k0", 64'(bus0.co_k), 64'd60);
    chk("end_n0", 64'(bus0.co_n), 64'd7);
    chk("end_pinc0", 64'(bus0.phase_inc), 64'd8947849);
    chk("end_trig0", 64'(tc0), 64'd0);
    chk("wrap_k1", 64'(bus1.co_k), 64'd1);
    chk("wrap_n1", 64'(bus1.co_n), 64'd0);
    chk("wrap_pinc1", 64'(bus1.phase_inc), 64'd536870912);
    chk("wrap_busy1", 64'(bus1.busy), 64'd1);
    chk("wrap_done1", 64'(bus1.done), 64'd0);
    chk("wrap_trig1", 64'(tc1), 64'd16);
    frame();
    chk("hold_done0", 64'(bus0.done), 64'd1);
    chk("hold_pinc0", 64'(bus0.phase_inc), 64'd8947849);
    chk("hold_poff0", 64'(bus0.poff), 64'd3758096384);
    chk("wrap2_n1", 64'(bus1.co_n), 64'd1);
    chk("wrap2_trig1", 64'(tc1), 64'd16);

    for (int d = 2; d <= 99; d++) begin
      frame();
      chk($sformatf("loop%0d_n1", d), 64'(bus1.co_n), 64'(d % 8));
      chk($sformatf("loop%0d_k1", d), 64'(bus1.co_k), 64'(d / 8 + 1));
    end

    // Frame showing pattern 100; trigger-enable drops while its cam_trig pulse is running
    for (int c = 0; c < 48; c++) begin
      vs = (c < 4);
      if (c == 10) in1 = 1'b0;
      @(negedge clk_25);
      if (c == 10) chk("drop_pulse_active", 64'(bus1.cam_trig), 64'd1);
      if (c == 12) begin
        chk("drop_busy1", 64'(bus1.busy), 64'd0);
        chk("drop_trig1", 64'(bus1.cam_trig), 64'd0);
        chk("drop_done0", 64'(bus0.done), 64'd0);
        chk("drop_k1", 64'(bus1.co_k), 64'd13);
        chk("drop_n1", 64'(bus1.co_n), 64'd4);
        chk("drop_pinc1", 64'(bus1.phase_inc), 64'd41297762);
      end
    end
    frame();
    chk("idle_k1", 64'(bus1.co_k), 64'd1);
    chk("idle_n1", 64'(bus1.co_n), 64'd0);
    chk("idle_pinc1", 64'(bus1.phase_inc), 64'd536870912);
    chk("idle_poff1", 64'(bus1.poff), 64'd0);
    chk("idle_trig1", 64'(tc1), 64'd0);
    chk("idle_k0", 64'(bus0.co_k), 64'd1);
    chk("idle_pinc0", 64'(bus0.phase_inc), 64'd536870912);

    in1 = 1'b1;
    repeat (4) frame();
    chk("rerun_n1", 64'(bus1.co_n), 64'd1);
    chk("rerun_mark1", 64'(bus1.frame_mark), 64'd1);
    for (int c = 0; c < 10; c++) begin
      vs = (c < 4);
      @(negedge clk_25);
    end
    chk("pre_rst_trig1", 64'(bus1.cam_trig), 64'd1);
    reset = 1'b1;
    #1;
    chk_rst("mid0", bus0.phase_inc, bus0.poff, bus0.co_k, bus0.co_n,
            bus0.cam_trig, bus0.frame_mark, bus0.busy, bus0.done);
    chk_rst("mid1", bus1.phase_inc, bus1.poff, bus1.co_k, bus1.co_n,
            bus1.cam_trig, bus1.frame_mark, bus1.busy, bus1.done);
    in1 = 1'b0;
    repeat (2) @(negedge clk_25);
    reset = 1'b0;
    repeat (4) @(negedge clk_25);
    chk("post_rst_busy1", 64'(bus1.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
